// File: rtl/bram_tdp_pkg.sv
// rtl/bram_tdp_pkg.sv - shared constants, controller states and lane merge for bram_tdp_be
package bram_tdp_pkg;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  // Widest geometry the merge helper handles; callers zero-extend into it
  localparam int MERGE_DW = 512;
  localparam int MERGE_NB = 64;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } ctrl_state_e;

  function automatic logic [MERGE_DW-1:0] byte_merge(
    input logic [MERGE_DW-1:0] old_word,
    input logic [MERGE_DW-1:0] new_word,
    input logic [MERGE_NB-1:0] wbe,
    input int                  bwidth
  );
    logic [MERGE_DW-1:0] merged;
    int lane;
    merged = old_word;
    for (int b = 0; b < MERGE_DW; b++) begin
      lane = b / bwidth;
      if (lane < MERGE_NB && wbe[lane]) begin
        merged[b] = new_word[b];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/bram_tdp_rdport.sv
// rtl/bram_tdp_rdport.sv - per-port read data register, optional output stage and write-first bypass
module bram_tdp_rdport
  import bram_tdp_pkg::*;
#(
  parameter int DWIDTH   = 32,
  parameter int RDW_MODE = 0,
  parameter int OREG     = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rce_i,
  input  logic [DWIDTH-1:0] mem_word_i,
  input  logic              wr_hit_i,
  input  logic [DWIDTH-1:0] wr_word_i,
  output logic [DWIDTH-1:0] rq_o,
  output logic              rvalid_o
);

  logic [DWIDTH-1:0] data_d;
  logic [DWIDTH-1:0] data_q;
  logic              valid_q;

  always_comb begin
    data_d = mem_word_i;
    if (RDW_MODE == RDW_NEW && wr_hit_i) begin
      data_d = wr_word_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= rce_i;
      if (rce_i) begin
        data_q <= data_d;
      end
    end
  end

  if (OREG != 0) begin : g_oreg
    logic [DWIDTH-1:0] oreg_q;
    logic              ovalid_q;

    // Output stage only advances on valid data so rq holds across idle cycles
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        oreg_q   <= '0;
        ovalid_q <= 1'b0;
      end else begin
        ovalid_q <= valid_q;
        if (valid_q) begin
          oreg_q <= data_q;
        end
      end
    end

    assign rq_o     = oreg_q;
    assign rvalid_o = ovalid_q;
  end else begin : g_noreg
    assign rq_o     = data_q;
    assign rvalid_o = valid_q;
  end

endmodule

// File: rtl/bram_tdp_be.sv
// rtl/bram_tdp_be.sv - single-clock true-dual-port RAM with byte enables and post-reset clear sweep
module bram_tdp_be
  import bram_tdp_pkg::*;
#(
  parameter int AWIDTH     = 10,
  parameter int DWIDTH     = 32,
  parameter int BWIDTH     = 8,
  parameter int RDW_MODE   = 0,
  parameter int OREG       = 0,
  parameter int INIT_CLEAR = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     init_busy,
  input  logic                     rce_a,
  input  logic [AWIDTH-1:0]        ra_a,
  output logic [DWIDTH-1:0]        rq_a,
  output logic                     rvalid_a,
  input  logic                     wce_a,
  input  logic [AWIDTH-1:0]        wa_a,
  input  logic [DWIDTH-1:0]        wd_a,
  input  logic [DWIDTH/BWIDTH-1:0] wbe_a,
  input  logic                     rce_b,
  input  logic [AWIDTH-1:0]        ra_b,
  output logic [DWIDTH-1:0]        rq_b,
  output logic                     rvalid_b,
  input  logic                     wce_b,
  input  logic [AWIDTH-1:0]        wa_b,
  input  logic [DWIDTH-1:0]        wd_b,
  input  logic [DWIDTH/BWIDTH-1:0] wbe_b
);

  localparam int NBYTES = DWIDTH / BWIDTH;
  localparam int DEPTH  = 2 ** AWIDTH;

  if ((DWIDTH % BWIDTH) != 0 || DWIDTH > MERGE_DW || NBYTES > MERGE_NB) begin : g_bad_geometry
    $error("bram_tdp_be: DWIDTH must be an integral multiple of BWIDTH within merge limits");
  end

  function automatic logic [DWIDTH-1:0] merge_word(
    input logic [DWIDTH-1:0] old_word,
    input logic [DWIDTH-1:0] new_word,
    input logic [NBYTES-1:0] wbe
  );
    logic [MERGE_DW-1:0] full;
    full = byte_merge(MERGE_DW'(old_word), MERGE_DW'(new_word), MERGE_NB'(wbe), BWIDTH);
    return full[DWIDTH-1:0];
  endfunction

  logic [DWIDTH-1:0] mem_q [DEPTH];

  ctrl_state_e       state_q;
  logic [AWIDTH-1:0] sweep_addr_q;
  logic              init_busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= (INIT_CLEAR != 0) ? INIT : READY;
      sweep_addr_q <= '0;
      init_busy_q  <= (INIT_CLEAR != 0);
    end else begin
      case (state_q)
        INIT: begin
          sweep_addr_q <= sweep_addr_q + 1'b1;
          if (sweep_addr_q == {AWIDTH{1'b1}}) begin
            state_q     <= READY;
            init_busy_q <= 1'b0;
          end
        end
        default: begin
          init_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign init_busy = init_busy_q;

  logic              ready;
  logic              we_a;
  logic              we_b;
  logic              same_wr;
  logic [DWIDTH-1:0] wfirst_a;
  logic [DWIDTH-1:0] wdata_b_d;
  logic [DWIDTH-1:0] wdata_a_d;

  assign ready   = (state_q == READY);
  assign we_a    = ready & wce_a;
  assign we_b    = ready & wce_b;
  assign same_wr = we_a & we_b & (wa_a == wa_b);

  // Port A merges on top of port B's result so A wins on shared lanes
  always_comb begin
    wfirst_a  = merge_word(mem_q[wa_a], wd_a, wbe_a);
    wdata_b_d = merge_word(mem_q[wa_b], wd_b, wbe_b);
    wdata_a_d = merge_word(same_wr ? wdata_b_d : mem_q[wa_a], wd_a, wbe_a);
  end

  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      mem_q[sweep_addr_q] <= '0;
    end else begin
      if (we_b) begin
        mem_q[wa_b] <= wdata_b_d;
      end
      if (we_a) begin
        mem_q[wa_a] <= wdata_a_d;
      end
    end
  end

  logic rd_en_a;
  logic rd_en_b;
  logic hit_a;
  logic hit_b;

  assign rd_en_a = ready & rce_a;
  assign rd_en_b = ready & rce_b;
  assign hit_a   = we_a & (ra_a == wa_a);
  assign hit_b   = we_b & (ra_b == wa_b);

  bram_tdp_rdport #(
    .DWIDTH  (DWIDTH),
    .RDW_MODE(RDW_MODE),
    .OREG    (OREG)
  ) u_rd_a (
    .clk_i     (clk),
    .rst_i     (rst),
    .rce_i     (rd_en_a),
    .mem_word_i(mem_q[ra_a]),
    .wr_hit_i  (hit_a),
    .wr_word_i (wfirst_a),
    .rq_o      (rq_a),
    .rvalid_o  (rvalid_a)
  );

  bram_tdp_rdport #(
    .DWIDTH  (DWIDTH),
    .RDW_MODE(RDW_MODE),
    .OREG    (OREG)
  ) u_rd_b (
    .clk_i     (clk),
    .rst_i     (rst),
    .rce_i     (rd_en_b),
    .mem_word_i(mem_q[ra_b]),
    .wr_hit_i  (hit_b),
    .wr_word_i (wdata_b_d),
    .rq_o      (rq_b),
    .rvalid_o  (rvalid_b)
  );

endmodule

// File: doc/bram_tdp_be.md
# bram_tdp_be

Parametrised single-clock true-dual-port block RAM with per-byte write enables, selectable read-during-write behaviour, optional output register and a post-reset clear sweep. It succeeds the fixed-geometry two-clock TDP memory used by the BRAM inference tests. It is the behavioural target that the BRAM mapping flow must preserve, and it is instantiated directly in test designs at 32x512 through 4x4096 and wider geometries.

## Interface
- AWIDTH, 10, address width; depth = 2**AWIDTH words
- DWIDTH, 32, data width; must be a multiple of BWIDTH
- BWIDTH, 8, byte-lane width; NBYTES = DWIDTH/BWIDTH
- RDW_MODE, 0, same-port read-during-write: 0 = old data (read-first), 1 = new data (write-first)
- OREG, 0, 1 adds an output register stage per port
- INIT_CLEAR, 1, 1 enables the zero-fill sweep after reset

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- init_busy  out  1  high while the clear sweep runs
- rce_a / rce_b  in  1  read enable
- ra_a / ra_b  in  AWIDTH  read address
- rq_a / rq_b  out  DWIDTH  read data
- rvalid_a / rvalid_b  out  1  rq carries data for an accepted read
- wce_a / wce_b  in  1  write enable
- wa_a / wa_b  in  AWIDTH  write address
- wd_a / wd_b  in  DWIDTH  write data
- wbe_a / wbe_b  in  NBYTES  byte-lane write enables; lane i covers bits [i*BWIDTH +: BWIDTH]

## Operation
- Controller states: INIT and READY. rst forces INIT if INIT_CLEAR=1, otherwise READY.
- INIT: an internal counter writes zero to one word per cycle, addresses 0 to 2**AWIDTH-1, every word including the last. On the cycle it writes the last address, the controller goes to READY.
- In INIT, all rce and wce inputs are ignored and rvalid stays 0.
- Reset asserted mid-sweep restarts the sweep at address 0.
- Reset clears no memory contents by itself.
- Write: wce high in READY writes each lane whose wbe bit is 1. Lanes with wbe 0 keep their value. wbe all zero is a no-op.
- Dual write to the same address in one cycle: for each lane, port A wins if wbe_a is set; otherwise the lane takes port B's value if wbe_b is set.
- Read: rce high in READY captures mem[ra] into the port's data register.
- When rce is low, rq holds its last value and rvalid drops to 0 on the next clock edge.
- Same-port read and write to the same address in one cycle: RDW_MODE=0 returns the pre-write word. RDW_MODE=1 returns the post-write word, merged per lane by wbe.
- Cross-port collision (read on one port, write on the other, same address, same cycle): always returns the pre-write word, regardless of RDW_MODE.
- Write data is never checked against DWIDTH/BWIDTH; a non-integral ratio is an elaboration error.

## Timing
- Reset values: rq_a = rq_b = 0, rvalid_a = rvalid_b = 0, init_busy = INIT_CLEAR.
- init_busy deasserts on the first edge after the last sweep write, i.e. 2**AWIDTH cycles after rst deasserts. The first accepted access happens on that same edge.
- Read latency from the rce edge to rq/rvalid: 1 cycle if OREG=0, 2 cycles if OREG=1.
- With OREG=1, the output register loads only when the stage-1 valid bit is set, and rvalid is pipelined alongside it.
- Writes are visible to any read issued on the next cycle.
- Full throughput: one read and one write per port per cycle, with no stalls.

## Structure
- Package bram_tdp_pkg holds:
  - RDW_OLD and RDW_NEW constants
  - the controller state enum {INIT, READY}
  - the byte-merge function (old word, new word, wbe) -> merged word
- Sub-module bram_tdp_rdport, instantiated once per port, holds the read data register, the optional output register, rvalid pipelining and the same-port write-first bypass mux.
- The top level holds the memory array, the write arbitration, the sweep counter and the FSM.

## Test plan
- Sweep: rst pulse, then 1024 idle cycles. Required: init_busy falls exactly 1024 cycles after rst deasserts, then reads of addresses 0, 511 and 1023 all return 0.
- Reset mid-sweep: assert rst at sweep address 300 after writing garbage via backdoor. Required: the sweep restarts, busy lasts a full 1024 cycles, and address 1023 reads 0.
- Byte enables: write 0xDEADBEEF to address 5 with wbe 1111, then 0x11223344 with wbe 0101. Required: a read returns 0xDE22BE44.
- Dual-write collision: A writes 0xAAAAAAAA with wbe 0011 and B writes 0xBBBBBBBB with wbe 1111, both to address 9. Required: 0xBBBBAAAA.
- Read-during-write: address 3 holds 0x0; write 0xCAFEF00D on port A while reading on port A. Required: rq_a = 0x0 with RDW_MODE=0 and 0xCAFEF00D with RDW_MODE=1. A same-cycle read on port B returns 0x0 in both modes.
- Latency/hold: with OREG=1, issue back-to-back reads of addresses 1, 2, 3 then drop rce. Required: rvalid is high for exactly cycles 2–4 after the first rce, data arrives in order, and rq holds the address-3 data afterwards.
